// File: rtl/x7seg_pkg.sv
// Shared constants for the seven-segment display blocks: the blank pattern,
// the hex-to-segment table (active-low, bit 6 = a ... bit 0 = g), the blink
// phase type and a helper that sizes index/counter registers.
package x7seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic {
    PH_OFF = 1'b0,
    PH_ON  = 1'b1
  } blink_phase_e;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/x7seg_scan_if.sv
// Register-side bus of the display scanner: the value/attribute set written
// by the CPU, the one-cycle load strobe and the pending status flag.
interface x7seg_scan_if #(
  parameter int unsigned NDIG = 8
);

  logic [4*NDIG-1:0] x;
  logic [NDIG-1:0]   dp_in;
  logic [NDIG-1:0]   blank;
  logic [NDIG-1:0]   blink_mask;
  logic              load;
  logic              pending;

  modport master (
    output x,
    output dp_in,
    output blank,
    output blink_mask,
    output load,
    input  pending
  );

  modport slave (
    input  x,
    input  dp_in,
    input  blank,
    input  blink_mask,
    input  load,
    output pending
  );

endinterface

// File: rtl/x7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (abcdefg).
module x7seg_decode
  import x7seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Table lookup; every nibble value has an entry.
  always_comb begin
    seg = HEX_SEG[hex];
  end

endmodule

// File: rtl/x7seg_scan.sv
// Multiplexed N-digit seven-segment scanner for common-anode displays.
// A prescaler steps the lit digit every REFRESH_DIV cycles; new values are
// captured into staging on load and moved to the displayed shadow set only
// at the frame boundary, so a frame never mixes old and new digits.
// Optional blinking is compiled in with `define X7SEG_SCAN_BLINK_EN.
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int unsigned NDIG         = 8,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic            cclk,
  input  logic            clr,
  x7seg_scan_if.slave     bus,
  output logic            frame_tick,
  output logic [6:0]      a_to_g,
  output logic [NDIG-1:0] an,
  output logic            dp
);

  localparam int unsigned IW = idx_width(NDIG);
  localparam int unsigned PW = idx_width(REFRESH_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pres_q, pres_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          step, boundary;
  logic          tick_q, tick_d;

  logic [4*NDIG-1:0] stg_x_q, stg_x_d, shd_x_q, shd_x_d;
  logic [NDIG-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
  logic [NDIG-1:0]   stg_blank_q, stg_blank_d, shd_blank_q, shd_blank_d;
  logic              pending_q, pending_d;

  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic [3:0]      sel_nib;
  logic            sel_dp, sel_blank;
  logic [NDIG-1:0] an_lit;
  logic [6:0]      seg_dec;
  logic            blink_off;

`ifdef X7SEG_SCAN_BLINK_EN
  localparam int unsigned BW = idx_width(BLINK_FRAMES);
  localparam logic [BW-1:0] BF_LAST = BW'(BLINK_FRAMES - 1);

  logic [NDIG-1:0] stg_bm_q, stg_bm_d, shd_bm_q, shd_bm_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  blink_phase_e    phase_q, phase_d;
  logic            sel_bm;
`else
  logic blink_unused;
  assign blink_unused = ^{bus.blink_mask, BLINK_FRAMES[0]};
`endif

  // Refresh prescaler, digit index and frame-boundary detection.
  always_comb begin
    step     = (pres_q == PRE_LAST);
    boundary = step && (idx_q == IDX_LAST);
    pres_d   = step ? '0 : pres_q + 1'b1;
    idx_d    = idx_q;
    if (step) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    tick_d = boundary;
  end

  // Staging capture on load and frame-synchronous transfer to shadow.
  // A load on the boundary cycle both commits the older staging contents and
  // refills staging, so pending stays set for the following frame.
  always_comb begin
    stg_x_d     = stg_x_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    shd_x_d     = shd_x_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    pending_d   = pending_q;
`ifdef X7SEG_SCAN_BLINK_EN
    stg_bm_d    = stg_bm_q;
    shd_bm_d    = shd_bm_q;
`endif
    if (boundary && pending_q) begin
      shd_x_d     = stg_x_q;
      shd_dp_d    = stg_dp_q;
      shd_blank_d = stg_blank_q;
`ifdef X7SEG_SCAN_BLINK_EN
      shd_bm_d    = stg_bm_q;
`endif
    end
    if (boundary) begin
      pending_d = 1'b0;
    end
    if (bus.load) begin
      stg_x_d     = bus.x;
      stg_dp_d    = bus.dp_in;
      stg_blank_d = bus.blank;
`ifdef X7SEG_SCAN_BLINK_EN
      stg_bm_d    = bus.blink_mask;
`endif
      pending_d   = 1'b1;
    end
  end

`ifdef X7SEG_SCAN_BLINK_EN
  // Blink phase advances on the boundary itself, the same edge that raises
  // frame_tick, so each frame shows a single consistent phase.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (bcnt_q == BF_LAST) begin
        bcnt_d  = '0;
        phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end
`endif

  // Select the current digit's shadow attributes.
  always_comb begin
    sel_nib   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_lit    = '1;
`ifdef X7SEG_SCAN_BLINK_EN
    sel_bm    = 1'b0;
`endif
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        sel_nib   = shd_x_q[4*i +: 4];
        sel_dp    = shd_dp_q[i];
        sel_blank = shd_blank_q[i];
        an_lit[i] = 1'b0;
`ifdef X7SEG_SCAN_BLINK_EN
        sel_bm    = shd_bm_q[i];
`endif
      end
    end
  end

  x7seg_decode u_decode (
    .hex (sel_nib),
    .seg (seg_dec)
  );

  // Registered pin drive; blanked or blink-off digits go fully dark.
  always_comb begin
`ifdef X7SEG_SCAN_BLINK_EN
    blink_off = (phase_q == PH_OFF) && sel_bm;
`else
    blink_off = 1'b0;
`endif
    if (sel_blank || blink_off) begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
    end else begin
      an_d  = an_lit;
      seg_d = seg_dec;
      dp_d  = ~sel_dp;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge cclk) begin
    if (clr) begin
      pres_q      <= '0;
      idx_q       <= '0;
      tick_q      <= 1'b0;
      stg_x_q     <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '1;
      shd_x_q     <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '1;
      pending_q   <= 1'b0;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
`ifdef X7SEG_SCAN_BLINK_EN
      stg_bm_q    <= '0;
      shd_bm_q    <= '0;
      bcnt_q      <= '0;
      phase_q     <= PH_ON;
`endif
    end else begin
      pres_q      <= pres_d;
      idx_q       <= idx_d;
      tick_q      <= tick_d;
      stg_x_q     <= stg_x_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      shd_x_q     <= shd_x_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      pending_q   <= pending_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
`ifdef X7SEG_SCAN_BLINK_EN
      stg_bm_q    <= stg_bm_d;
      shd_bm_q    <= shd_bm_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
`endif
    end
  end

  assign frame_tick  = tick_q;
  assign a_to_g      = seg_q;
  assign an          = an_q;
  assign dp          = dp_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_x7seg_scan.sv
// Bench for x7seg_scan (4 digits, 4 cycles per digit, 2-frame blink).
// Stimulus queues each load with the clock edge that samples it; the monitor
// counts edges since reset, commits queued loads at frame boundaries and
// compares the pins every cycle against the expected display.
module tb_x7seg_scan;

  localparam int unsigned NDIG = 4;
  localparam int unsigned RD   = 4;
  localparam int unsigned BF   = 2;
  localparam int unsigned F    = NDIG * RD;

  logic            cclk = 1'b0;
  logic            clr;
  logic            frame_tick;
  logic [6:0]      a_to_g;
  logic [NDIG-1:0] an;
  logic            dp;

  x7seg_scan_if #(.NDIG(NDIG)) bus ();

  x7seg_scan #(
    .NDIG         (NDIG),
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF)
  ) dut (
    .cclk       (cclk),
    .clr        (clr),
    .bus        (bus),
    .frame_tick (frame_tick),
    .a_to_g     (a_to_g),
    .an         (an),
    .dp         (dp)
  );

  always #5 cclk = ~cclk;

  typedef struct {
    int unsigned m;
    logic [15:0] x;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    logic [3:0]  bm;
  } ld_t;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  dpv;
    logic [3:0]  blk;
    logic [3:0]  bm;
  } img_t;

  ld_t         q[$];
  img_t        shadow, prev;
  int unsigned cur_edge = 0;
  bit          live = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic img_t reset_img();
    img_t r;
    r.x = '0; r.dpv = '0; r.blk = '1; r.bm = '0;
    return r;
  endfunction

  // Monitor: track edges since reset, commit loads at boundaries, compare.
  always @(posedge cclk) begin
    ld_t         e;
    int unsigned d, j;
    bit          off, dark;
    logic [3:0]  onehot, nib;
    logic [NDIG-1:0] exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp, exp_pend, exp_tick;
    if (clr) begin
      live     = 1'b1;
      cur_edge = 0;
      shadow   = reset_img();
      prev     = reset_img();
      q.delete();
    end else if (live) begin
      cur_edge++;
      prev = shadow;
      if (cur_edge % F == 0) begin
        while (q.size() > 0 && q[0].m < cur_edge) begin
          e = q.pop_front();
          shadow.x = e.x; shadow.dpv = e.dpv; shadow.blk = e.blk; shadow.bm = e.bm;
        end
      end
    end
    #1;
    if (live) begin
      exp_an = '1; exp_seg = 7'b1111111; exp_dp = 1'b1; exp_tick = 1'b0;
      exp_pend = (q.size() != 0);
      if (cur_edge > 0) begin
        d = ((cur_edge - 1) / RD) % NDIG;
        j = (cur_edge - 1) / F;
`ifdef X7SEG_SCAN_BLINK_EN
        off = ((j / BF) % 2) == 1;
`else
        off = 1'b0;
`endif
        dark = prev.blk[d] || (off && prev.bm[d]);
        exp_tick = (cur_edge % F == 0);
        if (!dark) begin
          onehot  = 4'b0001 << d;
          nib     = prev.x[4*d +: 4];
          exp_an  = ~onehot;
          exp_seg = ref_seg(nib);
          exp_dp  = ~prev.dpv[d];
        end
      end
      n_cmp++;
      if (an !== exp_an || a_to_g !== exp_seg || dp !== exp_dp) begin
        n_bad++;
        $display("FAIL display edge=%0d: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                 cur_edge, an, a_to_g, dp, exp_an, exp_seg, exp_dp);
      end
      n_cmp++;
      if (bus.pending !== exp_pend) begin
        n_bad++;
        $display("FAIL pending edge=%0d: got %b want %b", cur_edge, bus.pending, exp_pend);
      end
      n_cmp++;
      if (frame_tick !== exp_tick) begin
        n_bad++;
        $display("FAIL frame_tick edge=%0d: got %b want %b", cur_edge, frame_tick, exp_tick);
      end
    end
  end

  task automatic idle(input int unsigned k);
    repeat (k) @(negedge cclk);
  endtask

  // Called at a negedge; the load is sampled by the next posedge.
  task automatic do_load(input logic [15:0] xv, input logic [3:0] dpv,
                         input logic [3:0] blk, input logic [3:0] bm);
    ld_t e;
    bus.x = xv; bus.dp_in = dpv; bus.blank = blk; bus.blink_mask = bm;
    bus.load = 1'b1;
    e.m = cur_edge + 1; e.x = xv; e.dpv = dpv; e.blk = blk; e.bm = bm;
    q.push_back(e);
    @(negedge cclk);
    bus.load = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge cclk);
    clr = 1'b0;
  endtask

  // Position so the next posedge is a frame boundary.
  task automatic wait_boundary();
    int unsigned guard = 0;
    while (((cur_edge + 1) % F) != 0 && guard < 2 * F) begin
      @(negedge cclk);
      guard++;
    end
    n_cmp++;
    if (guard >= 2 * F) begin
      n_bad++;
      $display("FAIL boundary_wait: got %0d cycles want < %0d", guard, 2 * F);
    end
  endtask

  initial begin
    logic [15:0] rx;
    logic [3:0]  rdp, rblk, rbm;
    clr = 1'b1;
    bus.x = '0; bus.dp_in = '0; bus.blank = '0; bus.blink_mask = '0; bus.load = 1'b0;
    repeat (3) @(negedge cclk);
    clr = 1'b0;

    do_load(16'h12AF, 4'b0100, 4'b0000, 4'b0000);
    idle(5 * F);

    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    idle(3);
    do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
    idle(2 * F);

    do_load(16'h9C3E, 4'b1010, 4'b1000, 4'b0000);
    idle(2 * F);
    wait_boundary();
    do_load(16'h5D70, 4'b0001, 4'b0000, 4'b0000);
    idle(3 * F);

    idle(5);
    do_load(16'h4B68, 4'b1111, 4'b0000, 4'b0000);
    idle(2);
    pulse_clr();
    idle(2 * F);

    do_load(16'h8888, 4'b0000, 4'b0000, 4'b0001);
    idle(6 * F);

    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 24));
      rx   = 16'($urandom);
      rdp  = 4'($urandom);
      rblk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      rbm  = 4'($urandom);
      if ($urandom_range(0, 4) == 0) wait_boundary();
      do_load(rx, rdp, rblk, rbm);
      if ($urandom_range(0, 3) == 0) do_load(16'($urandom), 4'($urandom), 4'b0000, 4'($urandom));
      if ($urandom_range(0, 19) == 0) pulse_clr();
    end
    idle(3 * F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000 ns, want finish earlier");
    $fatal(1);
  end

endmodule
